// File: rtl/chan_pkg.sv
// Shared definitions for the channel-select packer: tuser field positions,
// default bin index width and the packer state encoding.
package chan_pkg;

    localparam int FFT_AW_DEFAULT = 11;

    localparam int EOB_BIT   = 23;
    localparam int SHIFT_LSB = 16;
    localparam int SHIFT_MSB = 20;
    localparam int BIN_LSB   = 0;
    localparam int BIN_MSB   = 10;

    typedef enum logic {
        RUN   = 1'b0,
        CLOSE = 1'b1
    } state_t;

endpackage

// File: rtl/chan_mask_ram.sv
// 1-bit-wide simple dual-port RAM with registered read. A same-address
// write and read in one cycle return the old contents. Contents are not
// reset; the device power-up value is relied on to be all zeros.
module chan_mask_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic mem [2**AW];

    // Write port and registered read port; non-blocking update gives read-old-data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/chan_select_packer.sv
// Channel-select packer: forwards only mask-enabled FFT bins and packs the
// survivors of each frame into one AXI-Stream packet. A one-word hold
// register (H) keeps the latest enabled bin so tlast can be placed on it
// once the frame end is seen, even if the end bin itself is disabled.
module chan_select_packer
    import chan_pkg::*;
#(
    parameter int FFT_AW      = FFT_AW_DEFAULT,
    parameter int TUSER_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   sync_reset_n,
    input  logic [FFT_AW:0]        fft_size,
    input  logic                   mask_wr,
    input  logic [FFT_AW-1:0]      mask_addr,
    input  logic                   mask_din,
    input  logic                   s_axis_tvalid,
    input  logic [31:0]            s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [31:0]            m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            empty_cnt
);

    state_t state, state_nx;

    logic                   accept, o_free, consume;
    logic [FFT_AW:0]        bin_ext, last_bin;
    logic                   in_range, end_in;
    logic                   ram_q;

    logic                   p1_valid, p1_in_range, p1_end, p1_en;
    logic [31:0]            p1_data;
    logic [TUSER_WIDTH-1:0] p1_user;

    logic                   h_valid;
    logic [31:0]            h_data;
    logic [TUSER_WIDTH-1:0] h_user;

    logic                   o_load, o_sel_h, o_last, h_load, h_clear, empty_inc;
    logic [TUSER_WIDTH-1:0] o_user_nx;

    // Frame end is taken from tuser eob and the bin index, never from s_axis_tlast
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign accept   = s_axis_tvalid & s_axis_tready;
    assign o_free   = !m_axis_tvalid | m_axis_tready;
    assign bin_ext  = {1'b0, s_axis_tuser[FFT_AW-1:0]};
    assign last_bin = fft_size - (FFT_AW+1)'(1);
    // Out-of-range bins are neither enabled nor a frame end
    assign in_range = bin_ext < fft_size;
    assign end_in   = in_range & (s_axis_tuser[EOB_BIT] | (bin_ext == last_bin));
    assign p1_en    = ram_q & p1_in_range;

    assign s_axis_tready = !p1_valid | consume;

    chan_mask_ram #(.AW(FFT_AW)) u_mask (
        .clk     (clk),
        .wr_en   (mask_wr),
        .wr_addr (mask_addr),
        .wr_data (mask_din),
        .rd_en   (accept),
        .rd_addr (s_axis_tuser[FFT_AW-1:0]),
        .rd_data (ram_q)
    );

    // State register
    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath control: decide what P1, H and O do this cycle
    always_comb begin
        state_nx  = state;
        consume   = 1'b0;
        o_load    = 1'b0;
        o_sel_h   = 1'b0;
        o_last    = 1'b0;
        h_load    = 1'b0;
        h_clear   = 1'b0;
        empty_inc = 1'b0;
        case (state)
            RUN: begin
                if (p1_valid && o_free) begin
                    consume = 1'b1;
                    if (p1_en) begin
                        if (h_valid) begin
                            o_load  = 1'b1;
                            o_sel_h = 1'b1;
                        end
                        if (!p1_end) begin
                            h_load = 1'b1;
                        end else if (h_valid) begin
                            // Both H and P1 must leave; P1 parks in H and closes next cycle
                            h_load   = 1'b1;
                            state_nx = CLOSE;
                        end else begin
                            o_load = 1'b1;
                            o_last = 1'b1;
                        end
                    end else if (p1_end) begin
                        if (h_valid) begin
                            o_load  = 1'b1;
                            o_sel_h = 1'b1;
                            o_last  = 1'b1;
                            h_clear = 1'b1;
                        end else begin
                            empty_inc = 1'b1;
                        end
                    end
                end
            end
            CLOSE: begin
                if (o_free) begin
                    o_load   = 1'b1;
                    o_sel_h  = 1'b1;
                    o_last   = 1'b1;
                    h_clear  = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // Output tuser: source word with the eob bit replaced by tlast
    always_comb begin
        o_user_nx          = o_sel_h ? h_user : p1_user;
        o_user_nx[EOB_BIT] = o_last;
    end

    // P1 stage: captures the accepted beat alongside its registered mask bit
    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            p1_valid    <= 1'b0;
            p1_in_range <= 1'b0;
            p1_end      <= 1'b0;
            p1_data     <= '0;
            p1_user     <= '0;
        end else if (accept) begin
            p1_valid    <= 1'b1;
            p1_in_range <= in_range;
            p1_end      <= end_in;
            p1_data     <= s_axis_tdata;
            p1_user     <= s_axis_tuser;
        end else if (consume) begin
            p1_valid <= 1'b0;
        end
    end

    // Hold register: the most recent enabled bin awaiting its last flag
    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            h_valid <= 1'b0;
            h_data  <= '0;
            h_user  <= '0;
        end else if (h_load) begin
            h_valid <= 1'b1;
            h_data  <= p1_data;
            h_user  <= p1_user;
        end else if (h_clear) begin
            h_valid <= 1'b0;
        end
    end

    // Output register: loads a new beat or drops valid once accepted, else holds
    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (o_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= o_sel_h ? h_data : p1_data;
            m_axis_tuser  <= o_user_nx;
            m_axis_tlast  <= o_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Packet and empty-frame counters, both wrapping
    always_ff @(posedge clk or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            frame_cnt <= '0;
            empty_cnt <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (empty_inc) begin
                empty_cnt <= empty_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_chan_select_packer.sv
// Directed bench for chan_select_packer: drives FFT frames against chosen
// masks and compares every emitted beat with a hand-built expected list.
module tb_chan_select_packer;

    logic        clk = 1'b0;
    logic        sync_reset_n = 1'b0;
    logic [11:0] fft_size = 12'd8;
    logic        mask_wr = 1'b0;
    logic [10:0] mask_addr = '0;
    logic        mask_din = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic [23:0] s_user = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic [23:0] m_user;
    logic        m_last;
    logic        m_ready;
    logic [15:0] frame_cnt, empty_cnt;

    int total = 0;
    int bad = 0;
    int low_cnt = 0;
    bit rdy_rand = 1'b0;
    bit rdy_val = 1'b1;

    logic [31:0] got_data[$], exp_data[$];
    logic [23:0] got_user[$], exp_user[$];
    logic        got_last[$], exp_last[$];

    logic        stalled = 1'b0;
    logic [57:0] prev_out = '0;

    chan_select_packer #(.FFT_AW(11), .TUSER_WIDTH(24)) dut (
        .clk           (clk),
        .sync_reset_n  (sync_reset_n),
        .fft_size      (fft_size),
        .mask_wr       (mask_wr),
        .mask_addr     (mask_addr),
        .mask_din      (mask_din),
        .s_axis_tvalid (s_valid),
        .s_axis_tdata  (s_data),
        .s_axis_tuser  (s_user),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tvalid (m_valid),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .frame_cnt     (frame_cnt),
        .empty_cnt     (empty_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input int tag, input int bin);
        return {8'hA5, 8'(tag), 5'h00, 11'(bin)};
    endfunction

    function automatic logic [23:0] mk_user(input bit eob, input int bin);
        return {eob, 2'b10, 5'h0B, 5'h15, 11'(bin)};
    endfunction

    // Output ready: fixed level or random coin flip, updated just after each edge
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Collect accepted output beats and check stability while stalled
    always @(negedge clk) begin
        if (!sync_reset_n) begin
            stalled <= 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_stable", {6'd0, m_valid, m_last, m_user, m_data}, {6'd0, prev_out});
            end
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_user.push_back(m_user);
                got_last.push_back(m_last);
            end
            stalled  <= m_valid && !m_ready;
            prev_out <= {m_valid, m_last, m_user, m_data};
        end
    end

    task automatic send(input int bin, input bit eob, input int tag);
        s_valid = 1'b1;
        s_data  = mk_data(tag, bin);
        s_user  = mk_user(eob, bin);
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            low_cnt++;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic frame(input int tag, input int n, input int eob_bin);
        for (int b = 0; b < n; b++) begin
            send(b, b == eob_bin, tag);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input int a, input bit v);
        mask_wr   = 1'b1;
        mask_addr = 11'(a);
        mask_din  = v;
        @(posedge clk);
        #1;
        mask_wr = 1'b0;
    endtask

    task automatic expect_beat(input int tag, input int bin, input bit last);
        exp_data.push_back(mk_data(tag, bin));
        exp_user.push_back(mk_user(last, bin));
        exp_last.push_back(last);
    endtask

    task automatic check_beats(input string name);
        int w = 0;
        while ((m_valid || got_data.size() < exp_data.size()) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_drain"}, 64'(w < 400), 64'd1);
        chk({name, "_count"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", name, i), 64'(got_data[i]), 64'(exp_data[i]));
            chk($sformatf("%s_user%0d", name, i), 64'(got_user[i]), 64'(exp_user[i]));
            chk($sformatf("%s_last%0d", name, i), 64'(got_last[i]), 64'(exp_last[i]));
        end
        got_data.delete(); got_user.delete(); got_last.delete();
        exp_data.delete(); exp_user.delete(); exp_last.delete();
    endtask

    initial begin
        // Reset and reset values
        repeat (3) @(posedge clk);
        #1;
        sync_reset_n = 1'b1;
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_user", 64'(m_user), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_empty_cnt", 64'(empty_cnt), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int a = 0; a < 16; a++) wr_mask(a, 1'b0);

        // Sparse mask: bins 1 and 3
        fft_size = 12'd8;
        rdy_val  = 1'b1;
        wr_mask(1, 1'b1);
        wr_mask(3, 1'b1);
        expect_beat(1, 1, 1'b0);
        expect_beat(1, 3, 1'b1);
        frame(1, 8, -1);
        idle(4);
        check_beats("sparse");
        chk("sparse_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("sparse_empty_cnt", 64'(empty_cnt), 64'd0);

        // Empty mask, three frames
        wr_mask(1, 1'b0);
        wr_mask(3, 1'b0);
        low_cnt = 0;
        frame(2, 8, -1);
        frame(3, 8, -1);
        frame(4, 8, -1);
        idle(4);
        check_beats("empty");
        chk("empty_ready_low", 64'(low_cnt), 64'd0);
        chk("empty_empty_cnt", 64'(empty_cnt), 64'd3);
        chk("empty_frame_cnt", 64'(frame_cnt), 64'd1);

        // Full mask with random backpressure, two frames
        for (int a = 0; a < 8; a++) wr_mask(a, 1'b1);
        rdy_rand = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8; b++) expect_beat(10 + f, b, b == 7);
        end
        frame(10, 8, -1);
        frame(11, 8, -1);
        idle(4);
        check_beats("full_bp");
        rdy_rand = 1'b0;
        idle(2);
        chk("full_frame_cnt", 64'(frame_cnt), 64'd3);

        // CLOSE path: bins 6 and 7 only, two back-to-back frames
        for (int a = 0; a < 6; a++) wr_mask(a, 1'b0);
        low_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            expect_beat(20 + f, 6, 1'b0);
            expect_beat(20 + f, 7, 1'b1);
        end
        frame(20, 8, -1);
        frame(21, 8, -1);
        idle(4);
        check_beats("close");
        chk("close_ready_low", 64'(low_cnt), 64'd1);
        chk("close_frame_cnt", 64'(frame_cnt), 64'd5);

        // Early eob on bin 4, fft_size 16, mask bins 2 and 9
        fft_size = 12'd16;
        wr_mask(6, 1'b0);
        wr_mask(7, 1'b0);
        wr_mask(2, 1'b1);
        wr_mask(9, 1'b1);
        expect_beat(30, 2, 1'b1);
        expect_beat(30, 9, 1'b1);
        frame(30, 16, 4);
        idle(4);
        check_beats("eob");
        chk("eob_frame_cnt", 64'(frame_cnt), 64'd7);
        chk("eob_empty_cnt", 64'(empty_cnt), 64'd3);

        // Mask write colliding with the read of bin 5: old value applies
        fft_size = 12'd8;
        wr_mask(2, 1'b0);
        wr_mask(9, 1'b0);
        for (int b = 0; b < 8; b++) begin
            if (b == 5) begin
                mask_wr   = 1'b1;
                mask_addr = 11'd5;
                mask_din  = 1'b1;
            end
            send(b, 1'b0, 40);
            mask_wr = 1'b0;
        end
        idle(4);
        check_beats("collide_old");
        chk("collide_empty_cnt", 64'(empty_cnt), 64'd4);
        expect_beat(41, 5, 1'b1);
        frame(41, 8, -1);
        idle(4);
        check_beats("collide_new");
        chk("collide_frame_cnt", 64'(frame_cnt), 64'd8);

        // Reset mid-frame with the output stalled
        for (int a = 0; a < 8; a++) wr_mask(a, 1'b1);
        rdy_val = 1'b0;
        idle(2);
        send(0, 1'b0, 50);
        send(1, 1'b0, 50);
        send(2, 1'b0, 50);
        s_valid = 1'b1;
        s_data  = mk_data(50, 3);
        s_user  = mk_user(1'b0, 3);
        repeat (3) @(negedge clk);
        chk("stall_s_ready", 64'(s_ready), 64'd0);
        chk("stall_m_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #1;
        sync_reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_m_data", 64'(m_data), 64'd0);
        chk("mid_rst_m_user", 64'(m_user), 64'd0);
        chk("mid_rst_m_last", 64'(m_last), 64'd0);
        chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("mid_rst_empty_cnt", 64'(empty_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        sync_reset_n = 1'b1;
        rdy_val = 1'b1;
        got_data.delete(); got_user.delete(); got_last.delete();
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        for (int b = 0; b < 8; b++) expect_beat(60, b, b == 7);
        frame(60, 8, -1);
        idle(4);
        check_beats("post_rst");
        chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("post_rst_empty_cnt", 64'(empty_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
